// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard/scoreboard unit: MD tracking states and the
// register-match predicate used for every source/destination comparison.
package hazard_pkg;

  localparam int unsigned MAX_AW = 16;
  localparam logic [MAX_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } md_state_t;

  // Register 0 is hard-wired zero, so it never creates a dependency.
  function automatic logic match(input logic [MAX_AW-1:0] x,
                                 input logic [MAX_AW-1:0] y,
                                 input logic              used);
    return used & (x == y) & (y != REG_ZERO);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Decode-side hazard bus: F/D and D/X operand info in, stall/bubble and MD status out.
interface hazard_scoreboard_unit_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 7
) ();

  logic [REG_AW-1:0] fd_rs1;
  logic [REG_AW-1:0] fd_rs2;
  logic              fd_rs1_used;
  logic              fd_rs2_used;
  logic [REG_AW-1:0] fd_rd;
  logic              fd_rd_used;
  logic              fd_is_st;
  logic              fd_is_md;
  logic [REG_AW-1:0] dx_rd;
  logic              dx_is_ld;
  logic              dx_md_start;
  logic              md_done;
  logic              stall_fd;
  logic              bubble_dx;
  logic              md_busy;
  logic [CNT_W-1:0]  md_count;
  logic              md_timeout;

  modport master (
    output fd_rs1, fd_rs2, fd_rs1_used, fd_rs2_used, fd_rd, fd_rd_used,
           fd_is_st, fd_is_md, dx_rd, dx_is_ld, dx_md_start, md_done,
    input  stall_fd, bubble_dx, md_busy, md_count, md_timeout
  );

  modport slave (
    input  fd_rs1, fd_rs2, fd_rs1_used, fd_rs2_used, fd_rd, fd_rd_used,
           fd_is_st, fd_is_md, dx_rd, dx_is_ld, dx_md_start, md_done,
    output stall_fd, bubble_dx, md_busy, md_count, md_timeout
  );

endinterface

// File: rtl/hazard_scoreboard_unit_reg_match.sv
// Single register-dependency comparator: equal addresses, operand used, address nonzero.
module reg_match
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] a,
  input  logic [REG_AW-1:0] b,
  input  logic              used,
  output logic              hit_c
);

  assign hit_c = match(MAX_AW'(a), MAX_AW'(b), used);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Decode-stage hazard unit: load-use detection plus a one-entry scoreboard for the
// multi-cycle mult/div result, with a sticky watchdog on overdue MD completion.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned MD_LAT = 32,
  parameter int unsigned CNT_W  = 7
) (
  input  logic                   clock,
  input  logic                   reset,
  hazard_scoreboard_unit_if.slave hz
);

  localparam int unsigned TO_LIM = 2 * MD_LAT;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TO_LIM);
  localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(TO_LIM - 1);

  md_state_t         state_q, state_d;
  logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              to_q, to_d;
  logic              busy_q, busy_d;

  logic lu_rs1_c, lu_rs2_c, md_rs1_c, md_rs2_c, md_rd_c;
  logic lu_c, mh_c;

  reg_match #(.REG_AW(REG_AW)) u_lu_rs1 (
    .a(hz.fd_rs1), .b(hz.dx_rd), .used(hz.fd_rs1_used), .hit_c(lu_rs1_c));
  reg_match #(.REG_AW(REG_AW)) u_lu_rs2 (
    .a(hz.fd_rs2), .b(hz.dx_rd), .used(hz.fd_rs2_used), .hit_c(lu_rs2_c));
  reg_match #(.REG_AW(REG_AW)) u_md_rs1 (
    .a(hz.fd_rs1), .b(pend_rd_q), .used(hz.fd_rs1_used), .hit_c(md_rs1_c));
  reg_match #(.REG_AW(REG_AW)) u_md_rs2 (
    .a(hz.fd_rs2), .b(pend_rd_q), .used(hz.fd_rs2_used), .hit_c(md_rs2_c));
  reg_match #(.REG_AW(REG_AW)) u_md_rd (
    .a(hz.fd_rd), .b(pend_rd_q), .used(hz.fd_rd_used), .hit_c(md_rd_c));

  // Store data on rs2 is bypassed M->M, so it does not need the load-use bubble.
  assign lu_c = hz.dx_is_ld & (lu_rs1_c | (lu_rs2_c & ~hz.fd_is_st));
  assign mh_c = (busy_q & (md_rs1_c | md_rs2_c | md_rd_c)) |
                (hz.fd_is_md & (state_q == BUSY));

  assign hz.stall_fd   = lu_c | mh_c;
  assign hz.bubble_dx  = lu_c | mh_c;
  assign hz.md_busy    = busy_q;
  assign hz.md_count   = cnt_q;
  assign hz.md_timeout = to_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      pend_rd_q <= '0;
      cnt_q     <= '0;
      to_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_rd_q <= pend_rd_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      busy_q    <= busy_d;
    end
  end

  // MD scoreboard next state; a completion in BUSY wins over a (stall-prevented) new issue.
  always_comb begin
    state_d   = state_q;
    pend_rd_d = pend_rd_q;
    cnt_d     = cnt_q;
    to_d      = to_q;
    case (state_q)
      IDLE: begin
        if (hz.dx_md_start) begin
          state_d   = BUSY;
          pend_rd_d = hz.dx_rd;
          cnt_d     = '0;
        end
      end
      BUSY: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_TRIP) to_d = 1'b1;
        if (hz.md_done) state_d = DRAIN;
      end
      DRAIN: begin
        if (hz.dx_md_start) begin
          state_d   = BUSY;
          pend_rd_d = hz.dx_rd;
          cnt_d     = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: load-use, store exemption, zero register,
// MD scoreboard stall/release, back-to-back MD, watchdog and mid-MD reset.
module tb_hazard_scoreboard_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  hazard_scoreboard_unit_if #(.REG_AW(5), .CNT_W(7)) hz ();

  hazard_scoreboard_unit #(.REG_AW(5), .MD_LAT(32), .CNT_W(7)) dut (
    .clock(clk),
    .reset(rst),
    .hz   (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    hz.fd_rs1 = '0; hz.fd_rs2 = '0; hz.fd_rd = '0;
    hz.fd_rs1_used = 1'b0; hz.fd_rs2_used = 1'b0; hz.fd_rd_used = 1'b0;
    hz.fd_is_st = 1'b0; hz.fd_is_md = 1'b0;
    hz.dx_rd = '0; hz.dx_is_ld = 1'b0; hz.dx_md_start = 1'b0; hz.md_done = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    settle();
    total++;
    if ({hz.stall_fd, hz.bubble_dx, hz.md_busy, hz.md_timeout} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags stall/bubble/busy/timeout=%b exp=0000",
                      {hz.stall_fd, hz.bubble_dx, hz.md_busy, hz.md_timeout});
    end
    total++;
    if (hz.md_count !== 7'd0) begin
      bad++; $display("FAIL reset_count md_count=%0d exp=0", hz.md_count);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    hz.dx_is_ld = 1'b1; hz.dx_rd = 5'd5;
    hz.fd_rs1 = 5'd5; hz.fd_rs1_used = 1'b1;
    settle();
    total++;
    if ({hz.stall_fd, hz.bubble_dx} !== 2'b11) begin
      bad++; $display("FAIL lu_rs1 stall/bubble=%b exp=11", {hz.stall_fd, hz.bubble_dx});
    end
    // Load moves to M, D/X now holds the bubble; F/D still holds the consumer.
    step();
    hz.dx_is_ld = 1'b0; hz.dx_rd = 5'd0;
    settle();
    total++;
    if ({hz.stall_fd, hz.bubble_dx} !== 2'b00) begin
      bad++; $display("FAIL lu_release stall/bubble=%b exp=00", {hz.stall_fd, hz.bubble_dx});
    end
    hz.dx_is_ld = 1'b1; hz.dx_rd = 5'd7;
    hz.fd_rs1 = 5'd7; hz.fd_rs1_used = 1'b0;
    settle();
    total++;
    if (hz.stall_fd !== 1'b0) begin
      bad++; $display("FAIL lu_unused stall_fd=%b exp=0", hz.stall_fd);
    end
    hz.fd_rs2 = 5'd7; hz.fd_rs2_used = 1'b1;
    settle();
    total++;
    if (hz.stall_fd !== 1'b1) begin
      bad++; $display("FAIL lu_rs2 stall_fd=%b exp=1", hz.stall_fd);
    end
    step();
  endtask

  task automatic test_store_exempt();
    clear_inputs();
    hz.dx_is_ld = 1'b1; hz.dx_rd = 5'd5;
    hz.fd_is_st = 1'b1; hz.fd_rs2 = 5'd5; hz.fd_rs2_used = 1'b1;
    hz.fd_rs1 = 5'd3; hz.fd_rs1_used = 1'b1;
    settle();
    total++;
    if (hz.stall_fd !== 1'b0) begin
      bad++; $display("FAIL st_data_exempt stall_fd=%b exp=0", hz.stall_fd);
    end
    hz.fd_rs1 = 5'd5;
    settle();
    total++;
    if ({hz.stall_fd, hz.bubble_dx} !== 2'b11) begin
      bad++; $display("FAIL st_addr_lu stall/bubble=%b exp=11", {hz.stall_fd, hz.bubble_dx});
    end
    step();
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    hz.dx_is_ld = 1'b1; hz.dx_rd = 5'd0;
    hz.fd_rs1 = 5'd0; hz.fd_rs1_used = 1'b1;
    settle();
    total++;
    if (hz.stall_fd !== 1'b0) begin
      bad++; $display("FAIL lu_r0 stall_fd=%b exp=0", hz.stall_fd);
    end
    hz.dx_is_ld = 1'b0;
    hz.dx_md_start = 1'b1;
    step();
    hz.dx_md_start = 1'b0;
    hz.fd_rs2 = 5'd0; hz.fd_rs2_used = 1'b1; hz.fd_rd = 5'd0; hz.fd_rd_used = 1'b1;
    settle();
    total++;
    if ({hz.md_busy, hz.stall_fd} !== 2'b10) begin
      bad++; $display("FAIL md_r0 busy/stall=%b exp=10", {hz.md_busy, hz.stall_fd});
    end
    hz.md_done = 1'b1;
    step();
    hz.md_done = 1'b0;
    step();
    // A stray completion pulse while idle must not restart tracking.
    hz.md_done = 1'b1;
    step();
    hz.md_done = 1'b0;
    settle();
    total++;
    if (hz.md_busy !== 1'b0) begin
      bad++; $display("FAIL md_done_idle md_busy=%b exp=0", hz.md_busy);
    end
  endtask

  task automatic test_md_stall();
    clear_inputs();
    hz.dx_md_start = 1'b1; hz.dx_rd = 5'd8;
    step();
    hz.dx_md_start = 1'b0; hz.dx_rd = 5'd0;
    hz.fd_rs2 = 5'd8; hz.fd_rs2_used = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 31) hz.md_done = 1'b1;
      settle();
      total++;
      if ({hz.stall_fd, hz.bubble_dx} !== 2'b11 || hz.md_count !== 7'(i)) begin
        bad++; $display("FAIL md_busy_stall cyc=%0d stall/bubble=%b count=%0d exp=11 count=%0d",
                        i, {hz.stall_fd, hz.bubble_dx}, hz.md_count, i);
      end
      step();
    end
    hz.md_done = 1'b0;
    settle();
    total++;
    if ({hz.md_busy, hz.stall_fd} !== 2'b11) begin
      bad++; $display("FAIL md_drain busy/stall=%b exp=11", {hz.md_busy, hz.stall_fd});
    end
    step();
    total++;
    if ({hz.md_busy, hz.stall_fd} !== 2'b00) begin
      bad++; $display("FAIL md_release busy/stall=%b exp=00", {hz.md_busy, hz.stall_fd});
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    hz.dx_md_start = 1'b1; hz.dx_rd = 5'd8;
    step();
    hz.dx_md_start = 1'b0;
    hz.fd_rd = 5'd8; hz.fd_rd_used = 1'b1;
    settle();
    total++;
    if (hz.stall_fd !== 1'b1) begin
      bad++; $display("FAIL md_waw stall_fd=%b exp=1", hz.stall_fd);
    end
    hz.fd_rd_used = 1'b0;
    hz.md_done = 1'b1;
    step();
    hz.md_done = 1'b0;
    hz.dx_md_start = 1'b1; hz.dx_rd = 5'd9;
    hz.fd_rs1_used = 1'b1; hz.fd_rs1 = 5'd9;
    settle();
    total++;
    if (hz.stall_fd !== 1'b0) begin
      bad++; $display("FAIL drain_new_rd stall_fd=%b exp=0", hz.stall_fd);
    end
    step();
    hz.dx_md_start = 1'b0;
    settle();
    total++;
    if ({hz.md_busy, hz.stall_fd, hz.md_count} !== {2'b11, 7'd0}) begin
      bad++; $display("FAIL drain_restart busy/stall=%b count=%0d exp=11 count=0",
                      {hz.md_busy, hz.stall_fd}, hz.md_count);
    end
    hz.fd_rs1 = 5'd8;
    settle();
    total++;
    if (hz.stall_fd !== 1'b0) begin
      bad++; $display("FAIL old_rd_free stall_fd=%b exp=0", hz.stall_fd);
    end
    // Completion and a new issue together in BUSY: completion wins, pend_rd stays 9.
    hz.md_done = 1'b1; hz.dx_md_start = 1'b1; hz.dx_rd = 5'd10;
    step();
    hz.md_done = 1'b0; hz.dx_md_start = 1'b0;
    hz.fd_rs1 = 5'd10;
    settle();
    total++;
    if (hz.stall_fd !== 1'b0) begin
      bad++; $display("FAIL done_wins_new stall_fd=%b exp=0", hz.stall_fd);
    end
    hz.fd_rs1 = 5'd9;
    settle();
    total++;
    if (hz.stall_fd !== 1'b1) begin
      bad++; $display("FAIL done_wins_old stall_fd=%b exp=1", hz.stall_fd);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_timeout();
    clear_inputs();
    hz.dx_md_start = 1'b1; hz.dx_rd = 5'd8;
    step();
    hz.dx_md_start = 1'b0; hz.dx_rd = 5'd0;
    step(); step(); step(); step(); step();
    hz.fd_is_md = 1'b1;
    settle();
    total++;
    if ({hz.stall_fd, hz.md_timeout, hz.md_count} !== {2'b10, 7'd5}) begin
      bad++; $display("FAIL md_struct stall/timeout=%b count=%0d exp=10 count=5",
                      {hz.stall_fd, hz.md_timeout}, hz.md_count);
    end
    hz.fd_is_md = 1'b0;
    for (int i = 5; i < 63; i++) step();
    settle();
    total++;
    if ({hz.md_timeout, hz.md_count} !== {1'b0, 7'd63}) begin
      bad++; $display("FAIL to_edge timeout=%b count=%0d exp=0 count=63",
                      hz.md_timeout, hz.md_count);
    end
    step();
    total++;
    if ({hz.md_timeout, hz.md_count} !== {1'b1, 7'd64}) begin
      bad++; $display("FAIL to_set timeout=%b count=%0d exp=1 count=64",
                      hz.md_timeout, hz.md_count);
    end
    step(); step();
    total++;
    if ({hz.md_timeout, hz.md_count} !== {1'b1, 7'd64}) begin
      bad++; $display("FAIL to_saturate timeout=%b count=%0d exp=1 count=64",
                      hz.md_timeout, hz.md_count);
    end
    hz.md_done = 1'b1;
    step();
    hz.md_done = 1'b0;
    hz.fd_is_md = 1'b1;
    settle();
    total++;
    if ({hz.md_busy, hz.stall_fd} !== 2'b10) begin
      bad++; $display("FAIL drain_no_struct busy/stall=%b exp=10", {hz.md_busy, hz.stall_fd});
    end
    hz.fd_is_md = 1'b0;
    step();
    total++;
    if ({hz.md_busy, hz.md_timeout} !== 2'b01) begin
      bad++; $display("FAIL to_sticky busy/timeout=%b exp=01", {hz.md_busy, hz.md_timeout});
    end
  endtask

  task automatic test_reset_mid_md();
    clear_inputs();
    hz.dx_md_start = 1'b1; hz.dx_rd = 5'd8;
    step();
    hz.dx_md_start = 1'b0; hz.dx_rd = 5'd0;
    for (int i = 0; i < 10; i++) step();
    total++;
    if (hz.md_count !== 7'd10) begin
      bad++; $display("FAIL pre_reset_count md_count=%0d exp=10", hz.md_count);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    hz.fd_rs1 = 5'd8; hz.fd_rs1_used = 1'b1;
    settle();
    total++;
    if ({hz.stall_fd, hz.bubble_dx, hz.md_busy, hz.md_timeout, hz.md_count} !== {4'b0000, 7'd0}) begin
      bad++; $display("FAIL mid_reset stall/bubble/busy/timeout=%b count=%0d exp=0000 count=0",
                      {hz.stall_fd, hz.bubble_dx, hz.md_busy, hz.md_timeout}, hz.md_count);
    end
    step();
    total++;
    if ({hz.md_busy, hz.stall_fd} !== 2'b00) begin
      bad++; $display("FAIL post_reset_idle busy/stall=%b exp=00", {hz.md_busy, hz.stall_fd});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_store_exempt();
    test_zero_reg();
    test_md_stall();
    test_back_to_back();
    test_timeout();
    test_reset_mid_md();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
